// File: rtl/cpu_defines_pkg.sv
// Shared MIPS decode definitions: instruction layout, operation codes,
// operand classes, decode-stage state and the execute payload record.
package cpu_defines;

    localparam int unsigned INST_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;

    typedef logic [REG_AW-1:0] Reg_addr_t;

    // R-format view; the I-format immediate is {rd, sa, funct}
    typedef struct packed {
        logic [5:0] opcode;
        Reg_addr_t  rs;
        Reg_addr_t  rt;
        Reg_addr_t  rd;
        logic [4:0] sa;
        logic [5:0] funct;
    } Inst_t;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_MOVZ = 6'h0A;
    localparam logic [5:0] FN_MOVN = 6'h0B;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MTHI = 6'h11;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MTLO = 6'h13;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    typedef enum logic [4:0] {
        OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
        OP_MOVN, OP_MOVZ, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI
    } Oper_t;

    // Operand class: I (rs, imm), R_0 (rs, rt), R_1 (sa, rt)
    typedef enum logic [1:0] {
        OPER_TYPE_NONE, OPER_TYPE_I, OPER_TYPE_R_0, OPER_TYPE_R_1
    } Oper_type_t;

    typedef enum logic [1:0] {ID_EMPTY, ID_FULL, ID_STALL} Id_state_t;

    typedef struct packed {
        Oper_t              oper;
        logic [DATA_W-1:0]  op1;
        logic [DATA_W-1:0]  op2;
        logic               wreg_write;
        Reg_addr_t          wreg_addr;
        logic [INST_W-1:0]  pc;
    } Ex_payload_t;

endpackage

// File: rtl/id_decode.sv
// Combinational opcode decode: operation, operand class, register fields
// and extended immediate.
//   inst          : fetched instruction
//   oper_c        : decoded operation (OP_NOP when unsupported)
//   oper_type_c   : operand class
//   rs_addr_c     : first read address (0 when unused)
//   rt_addr_c     : second read address (0 when unused)
//   wreg_write_c  : destination write enable
//   wreg_addr_c   : destination register
//   imm_c         : zero-extended immediate (shifted up for LUI)
//   sa_c          : shift amount
module id_decode
    import cpu_defines::*;
(
    input  Inst_t             inst,
    output Oper_t             oper_c,
    output Oper_type_t        oper_type_c,
    output Reg_addr_t         rs_addr_c,
    output Reg_addr_t         rt_addr_c,
    output logic              wreg_write_c,
    output Reg_addr_t         wreg_addr_c,
    output logic [DATA_W-1:0] imm_c,
    output logic [4:0]        sa_c
);

    logic [15:0] imm16;
    assign imm16 = {inst.rd, inst.sa, inst.funct};

    // Opcode / funct table
    always_comb begin
        oper_c       = OP_NOP;
        oper_type_c  = OPER_TYPE_NONE;
        rs_addr_c    = '0;
        rt_addr_c    = '0;
        wreg_write_c = 1'b0;
        wreg_addr_c  = '0;
        imm_c        = '0;
        sa_c         = '0;
        case (inst.opcode)
            OPC_SPECIAL: begin
                oper_type_c  = OPER_TYPE_R_0;
                rs_addr_c    = inst.rs;
                rt_addr_c    = inst.rt;
                wreg_write_c = 1'b1;
                wreg_addr_c  = inst.rd;
                case (inst.funct)
                    FN_AND:  oper_c = OP_AND;
                    FN_OR:   oper_c = OP_OR;
                    FN_XOR:  oper_c = OP_XOR;
                    FN_NOR:  oper_c = OP_NOR;
                    FN_SLLV: oper_c = OP_SLLV;
                    FN_SRLV: oper_c = OP_SRLV;
                    FN_SRAV: oper_c = OP_SRAV;
                    FN_MOVN: oper_c = OP_MOVN;
                    FN_MOVZ: oper_c = OP_MOVZ;
                    FN_MFHI: oper_c = OP_MFHI;
                    FN_MFLO: oper_c = OP_MFLO;
                    FN_MTHI: begin oper_c = OP_MTHI; wreg_write_c = 1'b0; end
                    FN_MTLO: begin oper_c = OP_MTLO; wreg_write_c = 1'b0; end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        oper_c      = (inst.funct == FN_SLL) ? OP_SLL :
                                      (inst.funct == FN_SRL) ? OP_SRL : OP_SRA;
                        oper_type_c = OPER_TYPE_R_1;
                        rs_addr_c   = '0;
                        sa_c        = inst.sa;
                    end
                    default: begin
                        oper_type_c  = OPER_TYPE_NONE;
                        rs_addr_c    = '0;
                        rt_addr_c    = '0;
                        wreg_write_c = 1'b0;
                        wreg_addr_c  = '0;
                    end
                endcase
            end
            OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI: begin
                oper_c       = (inst.opcode == OPC_ANDI) ? OP_ANDI :
                               (inst.opcode == OPC_ORI)  ? OP_ORI  :
                               (inst.opcode == OPC_XORI) ? OP_XORI : OP_LUI;
                oper_type_c  = OPER_TYPE_I;
                rs_addr_c    = inst.rs;
                wreg_write_c = 1'b1;
                wreg_addr_c  = inst.rt;
                imm_c        = (inst.opcode == OPC_LUI) ? {imm16, 16'h0000}
                                                        : {16'h0000, imm16};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode pipeline stage: decodes one instruction per cycle into an
// operation with forwarded 32-bit operands, interlocks on load-use hazards
// and handshakes with fetch and execute.
//   clk, rst_n             : clock, synchronous active-low reset
//   if_valid/if_ready      : fetch handshake (if_ready combinational)
//   if_inst, if_pc         : instruction and its PC
//   rf_raddr1/2, rf_rdata1/2 : same-cycle register-file read
//   fwd_we/waddr/wdata/is_load : forwarding sources, index 0 youngest
//   flush                  : drop accepted instruction and held output
//   ex_valid/ex_ready      : execute handshake
//   ex_oper .. ex_pc       : registered decoded payload
//   stall_cnt              : saturating load-use stall cycle count
module id_stage_pipe
    import cpu_defines::*;
#(
    parameter int unsigned FWD_PORTS = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             if_valid,
    output logic                             if_ready,
    input  Inst_t                            if_inst,
    input  logic [INST_W-1:0]                if_pc,
    output Reg_addr_t                        rf_raddr1,
    output Reg_addr_t                        rf_raddr2,
    input  logic [DATA_W-1:0]                rf_rdata1,
    input  logic [DATA_W-1:0]                rf_rdata2,
    input  logic [FWD_PORTS-1:0]             fwd_we,
    input  logic [FWD_PORTS-1:0][REG_AW-1:0] fwd_waddr,
    input  logic [FWD_PORTS-1:0][DATA_W-1:0] fwd_wdata,
    input  logic [FWD_PORTS-1:0]             fwd_is_load,
    input  logic                             flush,
    output logic                             ex_valid,
    input  logic                             ex_ready,
    output Oper_t                            ex_oper,
    output logic [DATA_W-1:0]                ex_op1,
    output logic [DATA_W-1:0]                ex_op2,
    output logic                             ex_wreg_write,
    output Reg_addr_t                        ex_wreg_addr,
    output logic [INST_W-1:0]                ex_pc,
    output logic [CNT_W-1:0]                 stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    Oper_t             dec_oper;
    Oper_type_t        dec_type;
    logic              dec_wreg_write;
    Reg_addr_t         dec_wreg_addr;
    logic [DATA_W-1:0] dec_imm;
    logic [4:0]        dec_sa;

    id_decode u_decode (
        .inst         (if_inst),
        .oper_c       (dec_oper),
        .oper_type_c  (dec_type),
        .rs_addr_c    (rf_raddr1),
        .rt_addr_c    (rf_raddr2),
        .wreg_write_c (dec_wreg_write),
        .wreg_addr_c  (dec_wreg_addr),
        .imm_c        (dec_imm),
        .sa_c         (dec_sa)
    );

    logic [DATA_W-1:0] val1, val2;
    logic              haz1, haz2, hazard;

    // Operand resolution: lowest-index forwarding hit wins, r0 is always 0
    always_comb begin
        val1 = rf_rdata1;
        val2 = rf_rdata2;
        haz1 = 1'b0;
        haz2 = 1'b0;
        for (int i = int'(FWD_PORTS) - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_waddr[i] == rf_raddr1) begin
                val1 = fwd_wdata[i];
                haz1 = fwd_is_load[i];
            end
            if (fwd_we[i] && fwd_waddr[i] == rf_raddr2) begin
                val2 = fwd_wdata[i];
                haz2 = fwd_is_load[i];
            end
        end
        if (rf_raddr1 == '0) begin val1 = '0; haz1 = 1'b0; end
        if (rf_raddr2 == '0) begin val2 = '0; haz2 = 1'b0; end
    end

    assign hazard = haz1 | haz2;

    Ex_payload_t payload_nxt, ex_q;

    // Assemble operands by class
    always_comb begin
        payload_nxt            = '0;
        payload_nxt.oper       = dec_oper;
        payload_nxt.wreg_write = dec_wreg_write;
        payload_nxt.wreg_addr  = dec_wreg_addr;
        payload_nxt.pc         = if_pc;
        case (dec_type)
            OPER_TYPE_I:   begin payload_nxt.op1 = val1; payload_nxt.op2 = dec_imm; end
            OPER_TYPE_R_0: begin payload_nxt.op1 = val1; payload_nxt.op2 = val2; end
            OPER_TYPE_R_1: begin payload_nxt.op1 = {27'b0, dec_sa}; payload_nxt.op2 = val2; end
            default: ;
        endcase
    end

    Id_state_t state, state_nxt;
    logic      out_free, load;

    // Output slot is free when it holds nothing or is being consumed
    assign out_free = (state != ID_FULL) || ex_ready;
    assign if_ready = rst_n && out_free && !hazard && !flush;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        if (flush) begin
            state_nxt = ID_EMPTY;
        end else if (if_valid && if_ready) begin
            state_nxt = ID_FULL;
            load      = 1'b1;
        end else if (out_free) begin
            state_nxt = (hazard && if_valid) ? ID_STALL : ID_EMPTY;
        end
    end

    // State, output register and stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ID_EMPTY;
            ex_valid  <= 1'b0;
            ex_q      <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ex_valid <= (state_nxt == ID_FULL);
            if (load) ex_q <= payload_nxt;
            if (if_valid && hazard && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign ex_oper       = ex_q.oper;
    assign ex_op1        = ex_q.op1;
    assign ex_op2        = ex_q.op2;
    assign ex_wreg_write = ex_q.wreg_write;
    assign ex_wreg_addr  = ex_q.wreg_addr;
    assign ex_pc         = ex_q.pc;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe with a behavioural reference model.
module tb_id_stage_pipe;
    import cpu_defines::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, if_valid, flush, ex_ready;
    logic [31:0]       if_inst, if_pc;
    logic [1:0]        fwd_we, fwd_is_load;
    logic [1:0][4:0]   fwd_waddr;
    logic [1:0][31:0]  fwd_wdata;
    logic [31:0]       rf_mem [32];

    // 16-bit counter instance
    logic        if_ready, ex_valid, ex_wreg_write;
    logic [4:0]  rf_raddr1, rf_raddr2, ex_wreg_addr;
    logic [31:0] rf_rdata1, rf_rdata2, ex_op1, ex_op2, ex_pc;
    Oper_t       ex_oper;
    logic [15:0] stall_cnt;
    // 2-bit counter instance, same stimulus
    logic        s_if_ready, s_ex_valid, s_ex_wreg_write;
    logic [4:0]  s_rf_raddr1, s_rf_raddr2, s_ex_wreg_addr;
    logic [31:0] s_rf_rdata1, s_rf_rdata2, s_ex_op1, s_ex_op2, s_ex_pc;
    Oper_t       s_ex_oper;
    logic [1:0]  s_stall_cnt;

    assign rf_rdata1   = rf_mem[rf_raddr1];
    assign rf_rdata2   = rf_mem[rf_raddr2];
    assign s_rf_rdata1 = rf_mem[s_rf_raddr1];
    assign s_rf_rdata2 = rf_mem[s_rf_raddr2];

    id_stage_pipe #(.FWD_PORTS(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_inst(if_inst), .if_pc(if_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_we(fwd_we),
        .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_is_load(fwd_is_load),
        .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_oper(ex_oper),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_wreg_write(ex_wreg_write),
        .ex_wreg_addr(ex_wreg_addr), .ex_pc(ex_pc), .stall_cnt(stall_cnt)
    );

    id_stage_pipe #(.FWD_PORTS(2), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(s_if_ready),
        .if_inst(if_inst), .if_pc(if_pc), .rf_raddr1(s_rf_raddr1), .rf_raddr2(s_rf_raddr2),
        .rf_rdata1(s_rf_rdata1), .rf_rdata2(s_rf_rdata2), .fwd_we(fwd_we),
        .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_is_load(fwd_is_load),
        .flush(flush), .ex_valid(s_ex_valid), .ex_ready(ex_ready), .ex_oper(s_ex_oper),
        .ex_op1(s_ex_op1), .ex_op2(s_ex_op2), .ex_wreg_write(s_ex_wreg_write),
        .ex_wreg_addr(s_ex_wreg_addr), .ex_pc(s_ex_pc), .stall_cnt(s_stall_cnt)
    );

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // kind: 0 unsupported, 1 reg+imm, 2 reg+reg, 3 shamt+reg
    function automatic void mdl_dec(input logic [31:0] inst, output Oper_t op,
                                    output int kind, output logic wr, output logic [4:0] wa);
        logic [5:0] opc, fn;
        opc = inst[31:26];
        fn  = inst[5:0];
        op = OP_NOP; kind = 0; wr = 1'b0; wa = 5'd0;
        if (opc == 6'h00) begin
            kind = 2; wr = 1'b1; wa = inst[15:11];
            case (fn)
                6'h24: op = OP_AND;   6'h25: op = OP_OR;
                6'h26: op = OP_XOR;   6'h27: op = OP_NOR;
                6'h04: op = OP_SLLV;  6'h06: op = OP_SRLV;  6'h07: op = OP_SRAV;
                6'h0B: op = OP_MOVN;  6'h0A: op = OP_MOVZ;
                6'h10: op = OP_MFHI;  6'h12: op = OP_MFLO;
                6'h11: begin op = OP_MTHI; wr = 1'b0; end
                6'h13: begin op = OP_MTLO; wr = 1'b0; end
                6'h00: begin op = OP_SLL; kind = 3; end
                6'h02: begin op = OP_SRL; kind = 3; end
                6'h03: begin op = OP_SRA; kind = 3; end
                default: begin kind = 0; wr = 1'b0; wa = 5'd0; end
            endcase
        end else begin
            case (opc)
                6'h0C: op = OP_ANDI; 6'h0D: op = OP_ORI;
                6'h0E: op = OP_XORI; 6'h0F: op = OP_LUI;
                default: op = OP_NOP;
            endcase
            if (op != OP_NOP) begin kind = 1; wr = 1'b1; wa = inst[20:16]; end
        end
    endfunction

    function automatic logic [4:0] mdl_ra(input logic [31:0] inst, input int port);
        Oper_t op; int kind; logic wr; logic [4:0] wa;
        mdl_dec(inst, op, kind, wr, wa);
        if (port == 1) return (kind == 1 || kind == 2) ? inst[25:21] : 5'd0;
        return (kind == 2 || kind == 3) ? inst[20:16] : 5'd0;
    endfunction

    function automatic logic [31:0] mval(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        for (int i = 0; i < 2; i++)
            if (fwd_we[i] && fwd_waddr[i] == r) return fwd_wdata[i];
        return rf_mem[r];
    endfunction

    function automatic logic mload(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        for (int i = 0; i < 2; i++)
            if (fwd_we[i] && fwd_waddr[i] == r) return fwd_is_load[i];
        return 1'b0;
    endfunction

    function automatic logic mhaz(input logic [31:0] inst);
        return mload(mdl_ra(inst, 1)) | mload(mdl_ra(inst, 2));
    endfunction

    logic        m_valid = 1'b0;
    Oper_t       m_oper = OP_NOP;
    logic [31:0] m_op1 = '0, m_op2 = '0, m_pc = '0;
    logic        m_wr = 1'b0;
    logic [4:0]  m_wa = '0;
    int          m_stalls = 0;

    always @(posedge clk) begin
        Oper_t op; int kind; logic wr; logic [4:0] wa; logic hz, rdy;
        if (!rst_n) begin
            m_valid  = 1'b0;
            m_stalls = 0;
        end else begin
            hz  = mhaz(if_inst);
            rdy = (!m_valid || ex_ready) && !hz && !flush;
            if (if_valid && hz) m_stalls++;
            if (flush) begin
                m_valid = 1'b0;
            end else if (if_valid && rdy) begin
                mdl_dec(if_inst, op, kind, wr, wa);
                m_valid = 1'b1; m_oper = op; m_wr = wr; m_wa = wa; m_pc = if_pc;
                m_op1 = (kind == 3) ? {27'd0, if_inst[10:6]} :
                        (kind == 0) ? 32'd0 : mval(if_inst[25:21]);
                m_op2 = (kind == 1) ? ((op == OP_LUI) ? {if_inst[15:0], 16'h0}
                                                      : {16'h0, if_inst[15:0]}) :
                        (kind == 0) ? 32'd0 : mval(if_inst[20:16]);
            end else if (ex_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare process: both instances against the model every cycle
    always @(negedge clk) begin
        logic exp_rdy;
        if (chk_en) begin
            exp_rdy = rst_n && (!m_valid || ex_ready) && !mhaz(if_inst) && !flush;
            chk("if_ready", 32'(if_ready), 32'(exp_rdy));
            chk("s_if_ready", 32'(s_if_ready), 32'(exp_rdy));
            chk("raddr1", 32'(rf_raddr1), 32'(mdl_ra(if_inst, 1)));
            chk("raddr2", 32'(rf_raddr2), 32'(mdl_ra(if_inst, 2)));
            chk("s_raddr1", 32'(s_rf_raddr1), 32'(mdl_ra(if_inst, 1)));
            chk("s_raddr2", 32'(s_rf_raddr2), 32'(mdl_ra(if_inst, 2)));
            chk("ex_valid", 32'(ex_valid), 32'(m_valid));
            chk("s_ex_valid", 32'(s_ex_valid), 32'(m_valid));
            chk("stall_cnt", 32'(stall_cnt), (m_stalls > 65535) ? 32'd65535 : 32'(m_stalls));
            chk("s_stall_cnt", 32'(s_stall_cnt), (m_stalls > 3) ? 32'd3 : 32'(m_stalls));
            if (m_valid) begin
                chk("ex_oper", 32'(ex_oper), 32'(m_oper));
                chk("ex_op1", ex_op1, m_op1);
                chk("ex_op2", ex_op2, m_op2);
                chk("ex_wreg_write", 32'(ex_wreg_write), 32'(m_wr));
                chk("ex_wreg_addr", 32'(ex_wreg_addr), 32'(m_wa));
                chk("ex_pc", ex_pc, m_pc);
                chk("s_ex_oper", 32'(s_ex_oper), 32'(m_oper));
                chk("s_ex_op1", s_ex_op1, m_op1);
                chk("s_ex_op2", s_ex_op2, m_op2);
                chk("s_ex_wreg_write", 32'(s_ex_wreg_write), 32'(m_wr));
                chk("s_ex_wreg_addr", 32'(s_ex_wreg_addr), 32'(m_wa));
                chk("s_ex_pc", s_ex_pc, m_pc);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1'b1; if_inst = inst; if_pc = pc;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " ex_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, " ex_oper"}, 32'(ex_oper), 32'(OP_NOP));
        chk({tag, " ex_op1"}, ex_op1, 32'd0);
        chk({tag, " ex_op2"}, ex_op2, 32'd0);
        chk({tag, " ex_pc"}, ex_pc, 32'd0);
        chk({tag, " ex_wreg_write"}, 32'(ex_wreg_write), 32'd0);
        chk({tag, " ex_wreg_addr"}, 32'(ex_wreg_addr), 32'd0);
        chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'd0);
        chk({tag, " s_stall_cnt"}, 32'(s_stall_cnt), 32'd0);
        chk({tag, " if_ready"}, 32'(if_ready), 32'd0);
    endtask

    localparam logic [31:0] I_ORI    = 32'h3421_00FF; // ori  r1, r1, 0xFF
    localparam logic [31:0] I_LUI    = 32'h3C02_ABCD; // lui  r2, 0xABCD
    localparam logic [31:0] I_AND    = 32'h0022_1824; // and  r3, r1, r2
    localparam logic [31:0] I_AND_R0 = 32'h0002_1824; // and  r3, r0, r2
    localparam logic [31:0] I_SLLV   = 32'h0022_2004; // sllv r4, r2, r1
    localparam logic [31:0] I_SRA    = 32'h0003_2883; // sra  r5, r3, 2

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0; flush = 1'b0;
        ex_ready = 1'b1; fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_is_load = '0;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000_0000 + 32'(i);
        rf_mem[1] = 32'h1234_0000;

        tick();
        chk_en = 1'b1;
        tick();
        chk_reset("reset");

        // ORI from the register file
        rst_n = 1'b1;
        issue(I_ORI, 32'h100);
        tick();
        chk("ori valid", 32'(ex_valid), 32'd1);
        chk("ori oper", 32'(ex_oper), 32'(OP_ORI));
        chk("ori op1", ex_op1, 32'h1234_0000);
        chk("ori op2", ex_op2, 32'h0000_00FF);
        chk("ori waddr", 32'(ex_wreg_addr), 32'd1);

        issue(I_LUI, 32'h104);
        tick();
        chk("lui op2", ex_op2, 32'hABCD_0000);
        chk("lui waddr", 32'(ex_wreg_addr), 32'd2);

        // Forwarding priority: youngest source wins on r1
        issue(I_AND, 32'h108);
        fwd_we = 2'b11;
        fwd_waddr[0] = 5'd1; fwd_wdata[0] = 32'd5;
        fwd_waddr[1] = 5'd1; fwd_wdata[1] = 32'd7;
        tick();
        chk("fwd pri op1", ex_op1, 32'd5);
        chk("fwd pri op2", ex_op2, 32'h1000_0002);

        fwd_waddr[1] = 5'd2; fwd_wdata[1] = 32'd9;
        tick();
        chk("fwd op1", ex_op1, 32'd5);
        chk("fwd op2", ex_op2, 32'd9);

        // A forwarded write to r0 never reaches an operand
        issue(I_AND_R0, 32'h10C);
        fwd_waddr[0] = 5'd0; fwd_wdata[0] = 32'hDEAD_BEEF;
        tick();
        chk("fwd r0 op1", ex_op1, 32'd0);
        chk("fwd r0 op2", ex_op2, 32'd9);

        issue(I_SRA, 32'h110);
        fwd_we = '0;
        tick();
        chk("sra op1", ex_op1, 32'd2);
        chk("sra op2", ex_op2, 32'h1000_0003);

        // Load-use interlock for three cycles
        issue(I_SLLV, 32'h114);
        fwd_we = 2'b01; fwd_waddr[0] = 5'd1; fwd_wdata[0] = 32'h77; fwd_is_load = 2'b01;
        for (int c = 0; c < 3; c++) begin
            #1 chk("stall if_ready", 32'(if_ready), 32'd0);
            tick();
            chk("stall drained", 32'(ex_valid), 32'd0);
        end
        chk("stall_cnt 3", 32'(stall_cnt), 32'd3);
        fwd_is_load = 2'b00;
        #1 chk("release if_ready", 32'(if_ready), 32'd1);
        tick();
        chk("sllv valid", 32'(ex_valid), 32'd1);
        chk("sllv oper", 32'(ex_oper), 32'(OP_SLLV));
        chk("sllv op1", ex_op1, 32'h77);
        chk("sllv op2", ex_op2, 32'h1000_0002);

        // Backpressure holds the payload
        issue(I_ORI, 32'h118);
        fwd_we = '0;
        ex_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("bp valid", 32'(ex_valid), 32'd1);
            chk("bp op1", ex_op1, 32'h77);
            chk("bp pc", ex_pc, 32'h114);
        end

        // Flush while full drops the held instruction
        flush = 1'b1;
        tick();
        chk("flush valid", 32'(ex_valid), 32'd0);
        flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        tick();
        chk("post flush valid", 32'(ex_valid), 32'd0);

        // Five more stall cycles saturate the 2-bit counter
        issue(I_SLLV, 32'h11C);
        fwd_we = 2'b01; fwd_waddr[0] = 5'd2; fwd_wdata[0] = 32'h55; fwd_is_load = 2'b01;
        repeat (5) tick();
        chk("sat stall_cnt", 32'(stall_cnt), 32'd8);
        chk("sat s_stall_cnt", 32'(s_stall_cnt), 32'd3);
        fwd_is_load = 2'b00;
        tick();
        chk("pre-reset valid", 32'(ex_valid), 32'd1);
        chk("pre-reset op2", ex_op2, 32'h55);

        // Reset with a held output
        ex_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        chk_reset("mid reset");
        rst_n = 1'b1; ex_ready = 1'b1; fwd_we = '0;
        issue(I_LUI, 32'h200);
        tick();
        chk("recover op2", ex_op2, 32'hABCD_0000);
        if_valid = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Registered MIPS instruction-decode pipeline stage between fetch and execute. It decodes one instruction per cycle into an operation plus fully resolved 32-bit operands, forwarding results from `FWD_PORTS` younger in-flight producers. It interlocks on load-use hazards and exchanges valid/ready handshakes with both neighbours. A saturating stall counter feeds performance monitoring.

## Interface
- `FWD_PORTS`, 2: number of forwarding sources; index 0 is the youngest (EX).
- `CNT_W`, 16: width of the stall counter.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset. One clock; reset is synchronous and active-low.
- `if_valid` in 1, `if_ready` out 1: fetch handshake.
- `if_inst` in 32 (`Inst_t`), `if_pc` in 32: instruction and its PC.
- `rf_raddr1`, `rf_raddr2` out 5: register-file read addresses, combinational from `if_inst`.
- `rf_rdata1`, `rf_rdata2` in 32: register-file data, same cycle.
- `fwd_we` in `FWD_PORTS`: per-source write enable.
- `fwd_waddr` in `FWD_PORTS`×5: per-source destination register.
- `fwd_wdata` in `FWD_PORTS`×32: per-source result data.
- `fwd_is_load` in `FWD_PORTS`: per-source flag; result is not yet available.
- `flush` in 1: discard the accepted instruction and the held output.
- `ex_valid` out 1, `ex_ready` in 1: execute handshake.
- `ex_oper` out `Oper_t`, `ex_op1` out 32, `ex_op2` out 32, `ex_wreg_write` out 1, `ex_wreg_addr` out 5, `ex_pc` out 32: decoded payload.
- `stall_cnt` out `CNT_W`: saturating count of load-use stall cycles.

## Operation
- **Decoded set:**
  - SPECIAL: AND OR XOR NOR SLL SRL SRA SLLV SRLV SRAV MOVN MOVZ MFHI MFLO MTHI MTLO.
  - Opcodes: ANDI ORI XORI LUI.
  - Anything else: `OP_NOP`, `wreg_write`=0, `op1`=`op2`=0. The instruction still passes downstream as valid.
- **Type I:**
  - `op1` = value(rs); `op2` = zero-extended imm.
  - LUI: `op2` = imm<<16.
  - Destination rt, write enabled.
- **Type R_0:** `op1` = value(rs), `op2` = value(rt), destination rd.
- **Type R_1 (SLL/SRL/SRA):** `op1` = {27'b0, sa}, `op2` = value(rt), destination rd.
- **MTHI/MTLO:** `wreg_write` = 0.
- **Operand resolution** (value(r)):
  - r=0 gives 0.
  - Otherwise take the lowest-index source i with `fwd_we[i]` and `fwd_waddr[i]`=r, and use `fwd_wdata[i]`.
  - If no source matches, use `rf_rdata`.
  - Unused read ports drive address 0.
- **Hazard:** asserted when a source operand r≠0 matches the lowest-index hit i and `fwd_is_load[i]`=1.
- **States:**
  - `EMPTY`: output invalid.
  - `FULL`: output valid, waiting for `ex_ready`.
  - `STALL`: hazard present. The output holds a bubble (`ex_valid`=0) once drained; `if_ready`=0.
- **Ready and acceptance:**
  - `if_ready` = (`EMPTY` or `ex_ready`) and not hazard and not `flush`.
  - Accept when `if_valid`&&`if_ready`: the output register loads and the next state is `FULL`.
  - If the current output is consumed but nothing is accepted, the next state is `STALL` when hazard && `if_valid`, otherwise `EMPTY`.
- **stall_cnt:** increments on each cycle with `if_valid`&&hazard; saturates at all-ones.
- **flush:** the next state is `EMPTY` and `ex_valid` drops the following cycle. `flush` overrides acceptance; `stall_cnt` is untouched.

## Timing
- **Reset:**
  - `ex_valid`=0, `ex_oper`=`OP_NOP`.
  - `ex_op1`/`ex_op2`/`ex_pc`=0, `ex_wreg_write`=0, `ex_wreg_addr`=0.
  - `stall_cnt`=0, state `EMPTY`.
  - `if_ready` is 0 while `rst_n`=0.
- **Latency:** 1 cycle from fetch handshake to `ex_valid`. Throughput 1 instruction/cycle with `ex_ready` held high.
- **Output stability:** the payload is stable while `ex_valid`&&!`ex_ready`.
- **Forwarding sampling:** forwarding and RF data are sampled in the acceptance cycle only.
- **Hazard release:** acceptance occurs the same cycle the hazard clears.
- **Reset mid-operation:** the held output is dropped with no partial handshake.

## Structure
- **`cpu_defines` package:** `Inst_t`, `Oper_t` enum, opcode/func constants, `OPER_TYPE_*` class macros, `Reg_addr_t`, and the new `Id_state_t` enum.
- **Sub-module `id_decode`:** purely combinational opcode→oper/type/field extraction, with every output defaulted.
- **Top level:** forwarding mux, hazard logic, FSM, output register and counter.

## Test plan
- **ORI** `if_inst`=0x3421_00FF with r1=0x1234_0000 from the RF, and no forwarding → next cycle `ex_oper`=`OP_ORI`, `op1`=0x1234_0000, `op2`=0x0000_00FF, `wreg_addr`=1.
- **LUI** 0x3C02_ABCD → `op2`=0xABCD_0000, `wreg_addr`=2.
- **Forwarding priority:** AND r3,r1,r2 with `fwd[0]` writing r1=5, `fwd[1]` writing r1=7 and r2=9 → `op1`=5, `op2`=9. A forwarded write to r0 is ignored (`op`=0).
- **Load-use interlock:** SLLV with `fwd_is_load[0]`=1 on rs for 3 cycles → `if_ready`=0 for 3 cycles, `ex_valid`=0 after the drain, `stall_cnt`=3, then acceptance on cycle 4.
- **Backpressure and flush:** `ex_ready`=0 for 2 cycles → payload stable. A `flush` while `FULL` → `ex_valid`=0 on the next cycle and the held instruction is never consumed.
- **Saturation and reset:** with `CNT_W`=2, 5 stall cycles → `stall_cnt`=3. Then `rst_n`=0 for one cycle → all outputs at their reset values.
